// File: rtl/rx_engine_pkg.sv
// Shared UART receive definitions: port ids, FSM encoding, baud count table.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rx_engine_pkg;

  // Default CPU port ids for the receive side
  localparam logic [15:0] RX_DATA_PORT_DEF = 16'h0000;
  localparam logic [15:0] RX_STAT_PORT_DEF = 16'h0001;

  // Wide enough for the slowest baud count (333333)
  localparam int CNT_W = 19;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } rx_state_t;

  // Clocks per bit at 100 MHz for each baud select code
  function automatic logic [CNT_W-1:0] baud_count(input logic [3:0] sel);
    logic [CNT_W-1:0] k;
    case (sel)
      4'd0:    k = CNT_W'(333333);
      4'd1:    k = CNT_W'(83333);
      4'd2:    k = CNT_W'(41667);
      4'd3:    k = CNT_W'(20833);
      4'd4:    k = CNT_W'(10417);
      4'd5:    k = CNT_W'(5208);
      4'd6:    k = CNT_W'(2604);
      4'd7:    k = CNT_W'(1736);
      4'd8:    k = CNT_W'(868);
      4'd9:    k = CNT_W'(434);
      4'd10:   k = CNT_W'(217);
      4'd11:   k = CNT_W'(109);
      default: k = CNT_W'(868);
    endcase
    return k;
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for the async rx line plus a falling-edge pulse.
// Latency: rx_s lags rx by 2 cycles; rx_fall pulses on the cycle rx_s first reads 0.
// Backpressure: none; free-running.
module rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);

  logic sync1;
  logic sync2;
  logic sync_prev;

  // Resample rx into the clk domain and keep one more stage for edge detect;
  // all stages reset to the idle-high line level so reset release cannot fake a start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync1     <= rx;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign rx_s    = sync2;
  assign rx_fall = sync_prev & ~sync2;

endmodule

// File: rtl/rx_engine.sv
// UART receiver with CPU-readable data and status ports; rxrdy is the interrupt level.
// Latency: stop bit sampled k/2 + (n+1)*k cycles after start detect; rxrdy follows shortly after.
// Backpressure: none; an unread byte is overwritten by the next frame and ovf is flagged.
module rx_engine
  import rx_engine_pkg::*;
#(
  parameter logic [15:0] RX_DATA_PORT = RX_DATA_PORT_DEF,
  parameter logic [15:0] RX_STAT_PORT = RX_STAT_PORT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic [3:0]  baud_in,
  input  logic        Eight,
  input  logic        Pen,
  input  logic        OHEL,
  input  logic [15:0] port_id,
  input  logic        read_strobe,
  output logic [15:0] in_port,
  output logic        rxrdy
);

  logic            rx_s;
  logic            rx_fall;

  rx_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] k_l;
  logic [3:0]      bit_idx;
  logic [3:0]      last_idx;
  logic [8:0]      shreg;
  logic            eight_l;
  logic            pen_l;
  logic            ohel_l;
  logic            stop_sample;

  logic [7:0]      rx_data;
  logic            perr;
  logic            ferr;
  logic            ovf;

  logic [7:0]      frm_data;
  logic            frm_par;
  logic            frm_perr;
  logic            commit;
  logic            data_rd;
  logic            stat_rd;

  rx_sync u_rx_sync (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  // Index of the final bit in the frame (data bits plus optional parity)
  assign last_idx = 4'd6 + {3'b000, eight_l} + {3'b000, pen_l};

  assign commit  = (state == DONE);
  assign data_rd = read_strobe & (port_id == RX_DATA_PORT);
  assign stat_rd = read_strobe & (port_id == RX_STAT_PORT);

  // Split the shift register into data byte and parity bit for the latched word length
  always_comb begin
    frm_data = {1'b0, shreg[6:0]};
    frm_par  = shreg[7];
    if (eight_l) begin
      frm_data = shreg[7:0];
      frm_par  = shreg[8];
    end
  end

  assign frm_perr = pen_l & ((^frm_data ^ frm_par) != ohel_l);

  // Frame FSM: latch settings at start, time each bit centre, shift bits in LSB first
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      k_l         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      eight_l     <= 1'b0;
      pen_l       <= 1'b0;
      ohel_l      <= 1'b0;
      stop_sample <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_fall) begin
            state   <= START;
            k_l     <= baud_count(baud_in);
            cnt     <= baud_count(baud_in) >> 1;
            eight_l <= Eight;
            pen_l   <= Pen;
            ohel_l  <= OHEL;
            shreg   <= '0;
          end
        end
        START: begin
          if (cnt == '0) begin
            // A line that is high again at mid start bit was a glitch
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              cnt     <= k_l - CNT_W'(1);
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shreg[bit_idx] <= rx_s;
            cnt            <= k_l - CNT_W'(1);
            bit_idx        <= bit_idx + 4'd1;
            if (bit_idx == last_idx) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == '0) begin
            stop_sample <= rx_s;
            state       <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Commit the frame into the CPU-visible registers; reads clear rxrdy / ovf otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
      rxrdy   <= 1'b0;
    end else if (commit) begin
      rx_data <= frm_data;
      perr    <= frm_perr;
      ferr    <= ~stop_sample;
      ovf     <= ovf | (rxrdy & ~data_rd);
      rxrdy   <= 1'b1;
    end else begin
      if (data_rd) begin
        rxrdy <= 1'b0;
      end
      if (stat_rd) begin
        ovf <= 1'b0;
      end
    end
  end

  // Read mux is decoded from port_id alone; read_strobe only gates the clear side effects
  always_comb begin
    in_port = '0;
    if (port_id == RX_DATA_PORT) begin
      in_port = {8'h00, rx_data};
    end else if (port_id == RX_STAT_PORT) begin
      in_port = {12'h000, ovf, ferr, perr, rxrdy};
    end
  end

endmodule

// File: tb/tb_rx_engine.sv
// Directed bench for rx_engine: serial frames driven bit by bit, CPU reads checked.
// Latency: n/a.
// Backpressure: n/a.
module tb_rx_engine;

  logic        clk;
  logic        reset;
  logic        rx;
  logic [3:0]  baud_in;
  logic        Eight;
  logic        Pen;
  logic        OHEL;
  logic [15:0] port_id;
  logic        read_strobe;
  logic [15:0] in_port;
  logic        rxrdy;

  int checks   = 0;
  int failures = 0;

  rx_engine dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .baud_in     (baud_in),
    .Eight       (Eight),
    .Pen         (Pen),
    .OHEL        (OHEL),
    .port_id     (port_id),
    .read_strobe (read_strobe),
    .in_port     (in_port),
    .rxrdy       (rxrdy)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one frame: start bit, nbits of bits LSB first, stop bit, then idle
  task automatic send_frame(input logic [8:0] bits, input int nbits, input logic stop_bit, input int k);
    rx = 1'b0;
    repeat (k) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx = bits[i];
      repeat (k) @(negedge clk);
    end
    rx = stop_bit;
    repeat (k) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  // Strobed CPU read: sample combinational in_port, clear side effect lands on the next edge
  task automatic rd(input logic [15:0] id, output logic [15:0] v);
    @(negedge clk);
    port_id     = id;
    read_strobe = 1'b1;
    #1 v = in_port;
    @(negedge clk);
    read_strobe = 1'b0;
    port_id     = 16'h0002;
  endtask

  // Unstrobed look at a port, no side effects
  task automatic peek(input logic [15:0] id, output logic [15:0] v);
    port_id = id;
    #1 v = in_port;
    port_id = 16'h0002;
  endtask

  logic [15:0] v;

  initial begin
    reset       = 1'b0;
    rx          = 1'b1;
    baud_in     = 4'd8;
    Eight       = 1'b1;
    Pen         = 1'b0;
    OHEL        = 1'b0;
    port_id     = 16'h0002;
    read_strobe = 1'b0;

    repeat (5) @(negedge clk);
    peek(16'h0000, v); check("reset_data", v, 16'h0000);
    peek(16'h0001, v); check("reset_stat", v, 16'h0000);
    check("reset_rxrdy", {15'd0, rxrdy}, 16'h0000);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // False start: 300 low cycles is shorter than half a bit at k=868
    rx = 1'b0;
    repeat (300) @(negedge clk);
    rx = 1'b1;
    repeat (500) @(negedge clk);
    check("false_start_rxrdy", {15'd0, rxrdy}, 16'h0000);
    peek(16'h0001, v); check("false_start_stat", v, 16'h0000);

    // 0x55 at baud 8, 8N1
    send_frame(9'h055, 8, 1'b1, 868);
    check("f55_rxrdy", {15'd0, rxrdy}, 16'h0001);
    rd(16'h0001, v); check("f55_stat", v, 16'h0001);
    rd(16'h0000, v); check("f55_data", v, 16'h0055);
    check("f55_rxrdy_clr", {15'd0, rxrdy}, 16'h0000);

    // 0xA3 with odd parity at baud 11: wrong then right parity bit
    baud_in = 4'd11;
    Pen     = 1'b1;
    OHEL    = 1'b1;
    send_frame({1'b0, 8'hA3}, 9, 1'b1, 109);
    rd(16'h0001, v); check("a3_badpar_stat", v, 16'h0003);
    rd(16'h0000, v); check("a3_badpar_data", v, 16'h00A3);
    send_frame({1'b1, 8'hA3}, 9, 1'b1, 109);
    rd(16'h0001, v); check("a3_goodpar_stat", v, 16'h0001);
    rd(16'h0000, v); check("a3_goodpar_data", v, 16'h00A3);

    // 7-bit 0x41 with a low stop bit
    Eight = 1'b0;
    Pen   = 1'b0;
    OHEL  = 1'b0;
    send_frame({2'b00, 7'h41}, 7, 1'b0, 109);
    check("f41_rxrdy", {15'd0, rxrdy}, 16'h0001);
    rd(16'h0001, v); check("f41_stat", v, 16'h0005);
    rd(16'h0000, v); check("f41_data", v, 16'h0041);

    // Overrun: two frames, no read in between, newest byte kept
    Eight = 1'b1;
    send_frame(9'h012, 8, 1'b1, 109);
    send_frame(9'h034, 8, 1'b1, 109);
    peek(16'h0005, v); check("other_port", v, 16'h0000);
    rd(16'h0000, v); check("ovf_data", v, 16'h0034);
    check("ovf_rxrdy_clr", {15'd0, rxrdy}, 16'h0000);
    rd(16'h0001, v); check("ovf_stat1", v, 16'h0008);
    rd(16'h0001, v); check("ovf_stat2", v, 16'h0000);

    // Reset in the middle of a frame, with a previous byte still pending
    send_frame(9'h0C3, 8, 1'b1, 109);
    check("pre_reset_rxrdy", {15'd0, rxrdy}, 16'h0001);
    rx = 1'b0;
    repeat (109) @(negedge clk);
    rx = 1'b1;
    repeat (109) @(negedge clk);
    rx = 1'b0;
    repeat (160) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_rxrdy", {15'd0, rxrdy}, 16'h0000);
    peek(16'h0000, v); check("midrst_data", v, 16'h0000);
    peek(16'h0001, v); check("midrst_stat", v, 16'h0000);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(9'h07E, 8, 1'b1, 109);
    rd(16'h0001, v); check("f7e_stat", v, 16'h0001);
    rd(16'h0000, v); check("f7e_data", v, 16'h007E);
    check("f7e_rxrdy_clr", {15'd0, rxrdy}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
